multicycle_control_fsm: RTL

Multicycle sequencer for the RV32I core datapath. It replaces single-cycle decode for builds where instruction fetch and data access share one memory port. The block steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects, write enables and memory handshake. Instruction classes are R-type, I-type ALU, load, store and branch (BEQ/BNE); every other encoding traps.

---
 rtl/multicycle_control_fsm.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects,
// write enables and the shared memory port handshake. Wait states on the
// memory port are bounded by a timeout that forces a sticky trap.
module multicycle_control_fsm #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       instr_retired,
   output logic       trap,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WR   = 4'd6,
      LOAD_WB  = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic [13:0]      moore_r;
   logic             moore_ret;
   logic             is_wait;
   logic             fetch_go;
   logic             br_taken;

   // Unconditional per-state outputs, packed as
   // {mem_req, mem_we, i_or_d, alu_src_a, alu_src_b, alu_op,
   //  reg_write, mem_to_reg, pc_src, instr_retired, trap}
   function automatic logic [13:0] moore_of(input state_t s);
      logic       mreq, mwe, iod, rw, m2r, psrc, ret, trp;
      logic [1:0] sa, sb, op;
      mreq = 1'b0; mwe = 1'b0; iod = 1'b0; rw = 1'b0; m2r = 1'b0;
      psrc = 1'b0; ret = 1'b0; trp = 1'b0;
      sa = 2'b00; sb = 2'b00; op = 2'b00;
      case (s)
         FETCH:    begin mreq = 1'b1; sb = 2'b01; end
         DECODE:   begin sa = 2'b10; sb = 2'b10; end
         EXEC_R:   begin sa = 2'b01; sb = 2'b00; op = 2'b10; end
         EXEC_I:   begin sa = 2'b01; sb = 2'b10; end
         MEM_ADDR: begin sa = 2'b01; sb = 2'b10; end
         MEM_RD:   begin mreq = 1'b1; iod = 1'b1; end
         MEM_WR:   begin mreq = 1'b1; mwe = 1'b1; iod = 1'b1; end
         LOAD_WB:  begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
         ALU_WB:   begin rw = 1'b1; ret = 1'b1; end
         BRANCH:   begin sa = 2'b01; op = 2'b01; psrc = 1'b1; ret = 1'b1; end
         TRAP:     trp = 1'b1;
         default:  trp = 1'b1;
      endcase
      return {mreq, mwe, iod, sa, sb, op, rw, m2r, psrc, ret, trp};
   endfunction

   // Next-state selection, including the memory-wait timeout escape to TRAP
   always_comb begin
      nxt     = state;
      is_wait = 1'b0;
      case (state)
         FETCH: begin
            is_wait = 1'b1;
            if (mem_ready)            nxt = DECODE;
            else if (cnt == CNT_LAST) nxt = TRAP;
         end
         DECODE: begin
            if (opcode == OP_R)                                   nxt = EXEC_R;
            else if (opcode == OP_I)                              nxt = EXEC_I;
            else if (opcode == OP_LOAD || opcode == OP_STORE)     nxt = MEM_ADDR;
            else if (opcode == OP_BRANCH && funct3[2:1] == 2'b00) nxt = BRANCH;
            else                                                  nxt = TRAP;
         end
         EXEC_R, EXEC_I: nxt = ALU_WB;
         MEM_ADDR: nxt = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            is_wait = 1'b1;
            if (mem_ready)            nxt = LOAD_WB;
            else if (cnt == CNT_LAST) nxt = TRAP;
         end
         MEM_WR: begin
            is_wait = 1'b1;
            if (mem_ready)            nxt = FETCH;
            else if (cnt == CNT_LAST) nxt = TRAP;
         end
         LOAD_WB, ALU_WB, BRANCH: nxt = FETCH;
         TRAP:    nxt = TRAP;
         default: nxt = TRAP;
      endcase
   end

   // State, wait counter and registered Moore outputs; reset wins over everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= FETCH;
         cnt     <= '0;
         moore_r <= moore_of(FETCH);
      end else begin
         state   <= nxt;
         moore_r <= moore_of(nxt);
         if (nxt != state)
            cnt <= '0;
         else if (is_wait && !mem_ready)
            cnt <= cnt + 1'b1;
      end
   end

   // Handshake- and branch-qualified strobes; no commit while reset is asserted
   always_comb begin
      fetch_go = (state == FETCH) && mem_ready && rst_n;
      br_taken = (funct3 == 3'b000 && alu_zero) || (funct3 == 3'b001 && !alu_zero);
      ir_write = fetch_go;
      pc_write = fetch_go || ((state == BRANCH) && br_taken);
      instr_retired = moore_ret || ((state == MEM_WR) && mem_ready && rst_n);
   end

   assign {mem_req, mem_we, i_or_d, alu_src_a, alu_src_b, alu_op,
           reg_write, mem_to_reg, pc_src, moore_ret, trap} = moore_r;
   assign state_o = state;

endmodule
